uart_encoder: RTL and testbench
===============================

# uart_encoder

Transmit-side framer for the inter-board UART link: periodically snapshots the local connection flag and 12-bit keeper position, packs them into a 3-byte frame, and pushes the bytes into the UART transmitter FIFO via a write-strobe/full handshake. The block sits between game control logic and the UART TX core. It produces exactly the frame format that the peer board's `uart_decoder` parses into `connect_corrected` and `keeper_pos`.

## Interface
Parameters:
- `FRAME_PERIOD`, default 100_000: clock cycles between frame launches; legal range ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset; the block is reset when `rst` = 0.
- `connect`  in  1  local "link alive" flag, sent in the header.
- `keeper_pos`  in  12  local keeper position, sent in the payload.
- `tx_full`  in  1  UART TX FIFO full; no write is issued while it is high.
- `tx_data`  out  8  byte being written to the FIFO.
- `wr_uart`  out  1  one-cycle FIFO write strobe; `tx_data` is valid only when it is 1.
- `busy`  out  1  high while a frame is being emitted (states HDR, LO, CHK).

## Operation
- Frame format, in order:
  - byte0 = {2'b10, connect, 1'b0, pos[11:8]}
  - byte1 = pos[7:0]
  - byte2 = byte0 ^ byte1 (XOR checksum)
- Period counter: free-running from 0 to FRAME_PERIOD-1, then wraps to 0. At terminal count it sets a one-deep `pending` flag.
- Coalescing: further ticks while `pending` = 1 are absorbed, so at most one frame is owed at any time.
- States:
  - IDLE: if `pending`, latch {connect, keeper_pos} into the snapshot, clear `pending`, go to HDR.
  - HDR: when `tx_full` = 0, emit byte0 and go to LO. Otherwise stay.
  - LO: when `tx_full` = 0, emit byte1 and go to CHK. Otherwise stay.
  - CHK: when `tx_full` = 0, emit byte2 and go to IDLE. Otherwise stay.
- "Emit" means: at that clock edge, register `wr_uart` <= 1 and `tx_data` <= byte. At every other edge, `wr_uart` <= 0 and `tx_data` holds its value.
- Frame content comes only from the snapshot. Input changes after the IDLE→HDR edge do not affect the frame in flight.
- `pending` setting and `pending` clearing in the same cycle: clear wins only if the IDLE→HDR launch happens in that edge. Otherwise the flag stays set, so no tick is lost.
- `busy` is registered and equals 1 exactly while the state is HDR, LO or CHK.

## Timing
- Reset (`rst` = 0 at an edge) sets:
  - `tx_data` = 8'h00, `wr_uart` = 0, `busy` = 0
  - state IDLE, counter 0, `pending` = 0, snapshot 0
- Reset mid-frame aborts the frame: no further bytes of it are ever written.
- After reset release, the first `pending` is set FRAME_PERIOD cycles later, at counter wrap.
- With `tx_full` = 0 throughout:
  - edge N: IDLE→HDR (launch)
  - edges N+1, N+2, N+3: byte0, byte1, byte2 emitted
  - result: `wr_uart` high for 3 consecutive cycles, then the block is back in IDLE
- Each cycle with `tx_full` = 1 during HDR/LO/CHK adds exactly one cycle of stall. Byte order and byte values are unchanged.
- Rate limit: `wr_uart` is never high for more than 3 cycles per frame, and never high in IDLE.

## Test plan
- FRAME_PERIOD=16, connect=1, keeper_pos=12'hA5C, tx_full=0 → first frame 16 cycles after reset release; bytes 0xAA, 0x5C, 0xF6 on 3 consecutive `wr_uart` cycles; `busy` high for 3 cycles; next frame 16 cycles after the first launch.
- connect=0, keeper_pos=12'h123 → bytes 0x81, 0x23, 0xA2.
- Same frame as test 1 with `tx_full` held high for 5 cycles while in LO → byte0 emitted, then 5 cycles with no strobe, then 0x5C and 0xF6; total frame 8 cycles after launch.
- keeper_pos changed from 12'hA5C to 12'h0FF one cycle after launch → frame still carries 0xAA, 0x5C, 0xF6; the next frame carries 0x80, 0xFF, 0x7F.
- `rst`=0 for one cycle right after byte0 is emitted → `wr_uart`=0, `busy`=0, `tx_data`=0x00 the next cycle; no 0x5C or 0xF6 appears; a new full frame starts 16 cycles after release.
- `tx_full` held high for 40 cycles (FRAME_PERIOD=16) → exactly one frame emitted after release (coalesced); the subsequent frame launches at the next counter wrap.

Source files
------------

// File: rtl/uart_encoder_if.sv
// Byte-write handshake between the frame encoder and the UART TX FIFO.
// The encoder owns tx_data and wr_uart; the FIFO side reports tx_full.
interface uart_encoder_if;
    logic [7:0] tx_data;
    logic       wr_uart;
    logic       tx_full;

    modport master (
        output tx_data,
        output wr_uart,
        input  tx_full
    );

    modport slave (
        input  tx_data,
        input  wr_uart,
        output tx_full
    );
endinterface

// File: rtl/uart_encoder.sv
// Periodic 3-byte frame encoder: {hdr+pos[11:8]}, pos[7:0], xor checksum.
// Frames are built from a snapshot taken at launch and pushed into the TX FIFO.
module uart_encoder #(
    parameter int FRAME_PERIOD = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  connect,
    input  logic [11:0]           keeper_pos,
    output logic                  busy,
    uart_encoder_if.master        tx
);
    localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        LO   = 2'd2,
        CHK  = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pending_q;
    logic          pending_d;
    logic          snap_conn_q;
    logic [11:0]   snap_pos_q;
    logic [7:0]    tx_data_q;
    logic          wr_q;
    logic          busy_q;

    logic          tick;
    logic          launch;
    logic [7:0]    byte0;
    logic [7:0]    byte1;
    logic [7:0]    byte2;

    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        launch = (state_q == IDLE) && pending_q;
        // A tick landing on the launch edge is absorbed by the frame being launched.
        pending_d = launch ? 1'b0 : (pending_q | tick);
        byte0 = {2'b10, snap_conn_q, 1'b0, snap_pos_q[11:8]};
        byte1 = snap_pos_q[7:0];
        byte2 = byte0 ^ byte1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            snap_conn_q <= 1'b0;
            snap_pos_q  <= '0;
            tx_data_q   <= 8'h00;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            wr_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        snap_conn_q <= connect;
                        snap_pos_q  <= keeper_pos;
                        state_q     <= HDR;
                        busy_q      <= 1'b1;
                    end
                end
                HDR: begin
                    if (!tx.tx_full) begin
                        tx_data_q <= byte0;
                        wr_q      <= 1'b1;
                        state_q   <= LO;
                    end
                end
                LO: begin
                    if (!tx.tx_full) begin
                        tx_data_q <= byte1;
                        wr_q      <= 1'b1;
                        state_q   <= CHK;
                    end
                end
                CHK: begin
                    if (!tx.tx_full) begin
                        tx_data_q <= byte2;
                        wr_q      <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx.tx_data = tx_data_q;
    assign tx.wr_uart = wr_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_uart_encoder.sv
// Directed bench for uart_encoder with FRAME_PERIOD=16; edge k counts rising
// edges since the latest reset release and outputs are sampled on the falling edge.
module tb_uart_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        connect = 1'b0;
    logic [11:0] keeper_pos = '0;
    logic        busy;

    uart_encoder_if tb_if();

    uart_encoder #(.FRAME_PERIOD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .connect    (connect),
        .keeper_pos (keeper_pos),
        .busy       (busy),
        .tx         (tb_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    int wr_cnt   = 0;
    int cnt_at   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge after rising edge e, counting strobes seen.
    task automatic to_edge(input int e);
        while (k < e) begin
            @(negedge clk);
            k++;
            if (tb_if.wr_uart === 1'b1) wr_cnt++;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b, input logic bsy);
        $display("edge %0d %s: wr_uart=%b tx_data=%h busy=%b", k, tag, tb_if.wr_uart, tb_if.tx_data, busy);
        check({tag, "_wr"}, 32'(tb_if.wr_uart), 32'd1);
        check({tag, "_data"}, 32'(tb_if.tx_data), 32'(b));
        check({tag, "_busy"}, 32'(busy), 32'(bsy));
    endtask

    initial begin
        tb_if.tx_full = 1'b0;
        connect       = 1'b1;
        keeper_pos    = 12'hA5C;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr", 32'(tb_if.wr_uart), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(tb_if.tx_data), 32'h00);
        rst = 1'b1; k = 0; wr_cnt = 0;

        // Frame 1: first launch at edge 17
        to_edge(16);
        check("t1_pre_busy", 32'(busy), 32'd0);
        check("t1_pre_cnt", 32'(wr_cnt), 32'd0);
        to_edge(17);
        check("t1_launch_busy", 32'(busy), 32'd1);
        check("t1_launch_wr", 32'(tb_if.wr_uart), 32'd0);
        to_edge(18); expect_byte("t1_b0", 8'hAA, 1'b1);
        to_edge(19); expect_byte("t1_b1", 8'h5C, 1'b1);
        to_edge(20); expect_byte("t1_b2", 8'hF6, 1'b0);
        to_edge(21);
        check("t1_after_wr", 32'(tb_if.wr_uart), 32'd0);
        check("t1_hold_data", 32'(tb_if.tx_data), 32'hF6);

        // Frame 2: different header/payload, launch 16 edges after the first
        connect = 1'b0; keeper_pos = 12'h123;
        to_edge(32);
        check("t2_pre_busy", 32'(busy), 32'd0);
        check("t2_pre_cnt", 32'(wr_cnt), 32'd3);
        to_edge(33);
        check("t2_launch_busy", 32'(busy), 32'd1);
        to_edge(34); expect_byte("t2_b0", 8'h81, 1'b1);
        to_edge(35); expect_byte("t2_b1", 8'h23, 1'b1);
        to_edge(36); expect_byte("t2_b2", 8'hA2, 1'b0);

        // Frame 3: five full cycles while in LO
        connect = 1'b1; keeper_pos = 12'hA5C;
        to_edge(49);
        check("t3_launch_busy", 32'(busy), 32'd1);
        check("t3_pre_cnt", 32'(wr_cnt), 32'd6);
        to_edge(50); expect_byte("t3_b0", 8'hAA, 1'b1);
        tb_if.tx_full = 1'b1;
        for (int e = 51; e <= 55; e++) begin
            to_edge(e);
            check("t3_stall_wr", 32'(tb_if.wr_uart), 32'd0);
            check("t3_stall_busy", 32'(busy), 32'd1);
        end
        check("t3_stall_data", 32'(tb_if.tx_data), 32'hAA);
        tb_if.tx_full = 1'b0;
        to_edge(56); expect_byte("t3_b1", 8'h5C, 1'b1);
        to_edge(57); expect_byte("t3_b2", 8'hF6, 1'b0);

        // Frame 4: inputs change after launch; snapshot must be used
        to_edge(65);
        check("t4_launch_busy", 32'(busy), 32'd1);
        connect = 1'b0; keeper_pos = 12'h0FF;
        to_edge(66); expect_byte("t4_b0", 8'hAA, 1'b1);
        to_edge(67); expect_byte("t4_b1", 8'h5C, 1'b1);
        to_edge(68); expect_byte("t4_b2", 8'hF6, 1'b0);
        to_edge(81);
        check("t4n_launch_busy", 32'(busy), 32'd1);
        to_edge(82); expect_byte("t4n_b0", 8'h80, 1'b1);
        to_edge(83); expect_byte("t4n_b1", 8'hFF, 1'b1);
        to_edge(84); expect_byte("t4n_b2", 8'h7F, 1'b0);

        // Frame 5: reset right after byte0 aborts the frame
        connect = 1'b1; keeper_pos = 12'hA5C;
        to_edge(97);
        check("t5_launch_busy", 32'(busy), 32'd1);
        to_edge(98); expect_byte("t5_b0", 8'hAA, 1'b1);
        rst = 1'b0;
        to_edge(99);
        check("t5_rst_wr", 32'(tb_if.wr_uart), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_data", 32'(tb_if.tx_data), 32'h00);
        cnt_at = wr_cnt;
        rst = 1'b1; k = 0;
        to_edge(16);
        check("t5_abort_cnt", 32'(wr_cnt), 32'(cnt_at));
        check("t5_pre_busy", 32'(busy), 32'd0);
        to_edge(17);
        check("t5r_launch_busy", 32'(busy), 32'd1);
        to_edge(18); expect_byte("t5r_b0", 8'hAA, 1'b1);
        to_edge(19); expect_byte("t5r_b1", 8'h5C, 1'b1);
        to_edge(20); expect_byte("t5r_b2", 8'hF6, 1'b0);

        // Frame 6: tx_full high for 40 edges (31..70), two ticks coalesce
        to_edge(30);
        tb_if.tx_full = 1'b1;
        to_edge(33);
        check("t6_launch_busy", 32'(busy), 32'd1);
        check("t6_launch_wr", 32'(tb_if.wr_uart), 32'd0);
        to_edge(70);
        check("t6_stall_cnt", 32'(wr_cnt), 32'(cnt_at + 3));
        check("t6_stall_busy", 32'(busy), 32'd1);
        tb_if.tx_full = 1'b0;
        to_edge(71); expect_byte("t6_b0", 8'hAA, 1'b1);
        to_edge(72); expect_byte("t6_b1", 8'h5C, 1'b1);
        to_edge(73); expect_byte("t6_b2", 8'hF6, 1'b0);
        to_edge(74);
        check("t6c_launch_busy", 32'(busy), 32'd1);
        check("t6c_launch_wr", 32'(tb_if.wr_uart), 32'd0);
        to_edge(75); expect_byte("t6c_b0", 8'hAA, 1'b1);
        to_edge(76); expect_byte("t6c_b1", 8'h5C, 1'b1);
        to_edge(77); expect_byte("t6c_b2", 8'hF6, 1'b0);
        to_edge(79);
        check("t6_idle_busy", 32'(busy), 32'd0);
        to_edge(80);
        check("t6_idle_busy2", 32'(busy), 32'd0);
        check("t6_total_cnt", 32'(wr_cnt), 32'(cnt_at + 9));
        to_edge(81);
        check("t6n_launch_busy", 32'(busy), 32'd1);
        to_edge(82); expect_byte("t6n_b0", 8'hAA, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
